central_report_collector: RTL and testbench

CENTRAL_REPORT_COLLECTOR -- requirements
Module: central_report_collector

---
 rtl/central_report_collector_pkg.sv | 53 +++++
 rtl/central_report_collector_if.sv | 30 +++
 rtl/central_report_collector_fifo.sv | 55 +++++
 rtl/central_report_collector.sv | 134 +++++++++++++
 tb/tb_central_report_collector.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/central_report_collector_pkg.sv
// Shared definitions for the central report collector.
// Holds the collector FSM state encoding, the report class encoding, the
// status-code constants used to classify a satellite report, the default
// report address, and a classifier helper used by the top module.
package central_report_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        ACK     = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        RC_BAD   = 3'd0,
        RC_CRASH = 3'd1,
        RC_HANG  = 3'd2,
        RC_OVF   = 3'd3,
        RC_MISM  = 3'd4
    } rpt_class_t;

    // Upper half of the status word selects the class.
    localparam logic [15:0] CODE_CRASH = 16'hDEAD;
    localparam logic [15:0] CODE_HANG  = 16'hBEEF;
    localparam logic [15:0] CODE_OVF   = 16'hC0DE;
    localparam logic [15:0] CODE_MISM  = 16'hFFFF;

    // Lower half must carry one of these sub-codes.
    localparam logic [15:0] SUB_A = 16'h0001;
    localparam logic [15:0] SUB_B = 16'h0002;

    localparam logic [31:0] DEFAULT_REPORT_ADDR = 32'h8000_0000;

    localparam int STATUS_W = 32;
    localparam int CNT_W    = 16;

    // Status-word classification only; address and write-enable legality
    // are judged by the caller.
    function automatic rpt_class_t classify_status(input logic [31:0] status);
        rpt_class_t cls;
        cls = RC_BAD;
        if ((status[15:0] == SUB_A) || (status[15:0] == SUB_B)) begin
            case (status[31:16])
                CODE_CRASH: cls = RC_CRASH;
                CODE_HANG:  cls = RC_HANG;
                CODE_OVF:   cls = RC_OVF;
                CODE_MISM:  cls = RC_MISM;
                default:    cls = RC_BAD;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/central_report_collector_if.sv
// Bus bundle between the collector and its environment.
// Carries the satellite report handshake (sat_req, sat_we, sat_addr_write,
// sat_wdata -> sat_write_done) and the host-side report queue head
// (rpt_valid, rpt_status, irq <- rpt_ready).
//   master : the satellite/host side, drives requests and rpt_ready.
//   slave  : the collector, drives completion, queue head and irq.
interface central_report_collector_if #(
    parameter int ADDR_WIDTH   = 32,
    parameter int EXT_RW_WIDTH = 256
);
    logic                    sat_req;
    logic                    sat_we;
    logic [ADDR_WIDTH-1:0]   sat_addr_write;
    logic [EXT_RW_WIDTH-1:0] sat_wdata;
    logic                    sat_write_done;
    logic                    rpt_valid;
    logic                    rpt_ready;
    logic [31:0]             rpt_status;
    logic                    irq;

    modport master (
        output sat_req, sat_we, sat_addr_write, sat_wdata, rpt_ready,
        input  sat_write_done, rpt_valid, rpt_status, irq
    );

    modport slave (
        input  sat_req, sat_we, sat_addr_write, sat_wdata, rpt_ready,
        output sat_write_done, rpt_valid, rpt_status, irq
    );
endinterface

// File: rtl/central_report_collector_fifo.sv
// report_fifo: first-word-fall-through queue of report status words.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (pointers only)
//   push/push_data : write request; accepted when not full, or when full
//                    and a pop happens in the same cycle
//   pop        : consume the head (ignored when empty)
//   full/empty : occupancy flags
//   head       : current head word, 0 while empty
module report_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    // Extra MSB distinguishes full from empty when the index bits match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             rd_en;
    logic             wr_en;

    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        rd_en = pop && !empty;
        // When full, the slot being written is the one the pop frees.
        wr_en = push && (!full || rd_en);
        head  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/central_report_collector.sv
// central_report_collector: accepts status reports from a satellite,
// classifies them, counts them per class and queues legal ones for a host.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : satellite handshake and report queue head (slave side)
//   clr_cnt   : zero all counters (wins over a same-cycle increment)
//   crash_cnt, hang_cnt, ovf_cnt, mism_cnt : per-class counts (saturating)
//   bad_cnt   : malformed or illegal reports
//   drop_cnt  : legal reports lost because the queue was full
// Flow: IDLE latches a request, CAPTURE classifies and pushes, ACK pulses
// sat_write_done, so done appears two cycles after the request is sampled.
module central_report_collector
    import central_report_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    EXT_RW_WIDTH = 256,
    parameter int                    FIFO_DEPTH   = 8,
    parameter logic [ADDR_WIDTH-1:0] REPORT_ADDR  = ADDR_WIDTH'(DEFAULT_REPORT_ADDR)
) (
    input  logic                      clk,
    input  logic                      rst,
    central_report_collector_if.slave bus,
    input  logic                      clr_cnt,
    output logic [CNT_W-1:0]          crash_cnt,
    output logic [CNT_W-1:0]          hang_cnt,
    output logic [CNT_W-1:0]          ovf_cnt,
    output logic [CNT_W-1:0]          mism_cnt,
    output logic [CNT_W-1:0]          bad_cnt,
    output logic [CNT_W-1:0]          drop_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             en);
        return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
    endfunction

    state_t                state;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [STATUS_W-1:0]   status_q;

    rpt_class_t cls;
    logic       capture;
    logic       rpt_ok;
    logic       push;
    logic       pop;
    logic       full;
    logic       empty;
    logic       drop;

    // Only the status word of the payload is meaningful.
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^bus.sat_wdata[EXT_RW_WIDTH-1:STATUS_W];

    always_comb begin
        cls     = classify_status(status_q);
        capture = (state == CAPTURE);
        rpt_ok  = we_q && (addr_q == REPORT_ADDR) && (cls != RC_BAD);
        push    = capture && rpt_ok;
        pop     = bus.rpt_ready && !empty;
        // A pop in the same cycle frees the slot, so a full queue still accepts.
        drop    = push && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            bus.sat_write_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.sat_write_done <= 1'b0;
                    if (bus.sat_req) state <= CAPTURE;
                end
                CAPTURE: begin
                    bus.sat_write_done <= 1'b1;
                    state              <= ACK;
                end
                ACK: begin
                    bus.sat_write_done <= 1'b0;
                    state              <= IDLE;
                end
                default: begin
                    bus.sat_write_done <= 1'b0;
                    state              <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((state == IDLE) && bus.sat_req) begin
            we_q     <= bus.sat_we;
            addr_q   <= bus.sat_addr_write;
            status_q <= bus.sat_wdata[STATUS_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            crash_cnt <= '0;
            hang_cnt  <= '0;
            ovf_cnt   <= '0;
            mism_cnt  <= '0;
            bad_cnt   <= '0;
            drop_cnt  <= '0;
        end else if (capture) begin
            crash_cnt <= sat_inc(crash_cnt, rpt_ok && (cls == RC_CRASH));
            hang_cnt  <= sat_inc(hang_cnt,  rpt_ok && (cls == RC_HANG));
            ovf_cnt   <= sat_inc(ovf_cnt,   rpt_ok && (cls == RC_OVF));
            mism_cnt  <= sat_inc(mism_cnt,  rpt_ok && (cls == RC_MISM));
            bad_cnt   <= sat_inc(bad_cnt,   !rpt_ok);
            drop_cnt  <= sat_inc(drop_cnt,  drop);
        end
    end

    report_fifo #(
        .WIDTH (STATUS_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (status_q),
        .pop       (bus.rpt_ready),
        .full      (full),
        .empty     (empty),
        .head      (bus.rpt_status)
    );

    assign bus.rpt_valid = !empty;
    assign bus.irq       = !empty;

endmodule

// File: tb/tb_central_report_collector.sv
// Directed bench for central_report_collector. Inputs change on the falling
// edge and outputs are sampled on the falling edge, away from the active edge.
module tb_central_report_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_cnt;
    logic [15:0] crash_cnt, hang_cnt, ovf_cnt, mism_cnt, bad_cnt, drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    central_report_collector_if #(.ADDR_WIDTH(32), .EXT_RW_WIDTH(256)) bus ();

    central_report_collector #(
        .ADDR_WIDTH   (32),
        .EXT_RW_WIDTH (256),
        .FIFO_DEPTH   (8),
        .REPORT_ADDR  (32'h8000_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .clr_cnt   (clr_cnt),
        .crash_cnt (crash_cnt),
        .hang_cnt  (hang_cnt),
        .ovf_cnt   (ovf_cnt),
        .mism_cnt  (mism_cnt),
        .bad_cnt   (bad_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input logic [31:0] addr, input logic [31:0] data, input logic we);
        bus.sat_req        = 1'b1;
        bus.sat_we         = we;
        bus.sat_addr_write = addr;
        // Junk in the upper payload bits must be ignored.
        bus.sat_wdata      = {{7{32'hA5A5_5A5A}}, data};
    endtask

    // Starts at a falling edge in IDLE, ends at the falling edge of the
    // following IDLE cycle. pop_cap/clr_cap are applied in the CAPTURE cycle.
    task automatic send(input logic [31:0] addr, input logic [31:0] data, input logic we,
                        input logic pop_cap, input logic clr_cap);
        drive_req(addr, data, we);
        @(negedge clk);
        bus.sat_req   = 1'b0;
        bus.rpt_ready = pop_cap;
        clr_cnt       = clr_cap;
        check("done_t1", {31'd0, bus.sat_write_done}, 32'd0);
        @(negedge clk);
        bus.rpt_ready = 1'b0;
        clr_cnt       = 1'b0;
        check("done_t2", {31'd0, bus.sat_write_done}, 32'd1);
        @(negedge clk);
        check("done_t3", {31'd0, bus.sat_write_done}, 32'd0);
    endtask

    task automatic pop_expect(input string tag, input logic [31:0] exp);
        check({tag, "_valid"}, {31'd0, bus.rpt_valid}, 32'd1);
        check({tag, "_status"}, bus.rpt_status, exp);
        bus.rpt_ready = 1'b1;
        @(negedge clk);
        bus.rpt_ready = 1'b0;
    endtask

    task automatic clear_counters();
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
    endtask

    logic [31:0] fill [8];

    initial begin
        fill[0] = 32'hDEAD0001; fill[1] = 32'hBEEF0002;
        fill[2] = 32'hC0DE0001; fill[3] = 32'hFFFF0001;
        fill[4] = 32'hDEAD0002; fill[5] = 32'hBEEF0001;
        fill[6] = 32'hC0DE0002; fill[7] = 32'hDEAD0001;

        rst = 1'b1; clr_cnt = 1'b0;
        bus.sat_req = 1'b0; bus.sat_we = 1'b0; bus.sat_addr_write = '0;
        bus.sat_wdata = '0; bus.rpt_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_valid",  {31'd0, bus.rpt_valid}, 32'd0);
        check("rst_irq",    {31'd0, bus.irq}, 32'd0);
        check("rst_done",   {31'd0, bus.sat_write_done}, 32'd0);
        check("rst_status", bus.rpt_status, 32'd0);
        check("rst_crash",  {16'd0, crash_cnt}, 32'd0);
        check("rst_bad",    {16'd0, bad_cnt}, 32'd0);
        check("rst_drop",   {16'd0, drop_cnt}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single crash report: done two cycles after the request is sampled
        drive_req(32'h8000_0000, 32'hDEAD0001, 1'b1);
        @(negedge clk);
        bus.sat_req = 1'b0;
        check("crash_done_t1",  {31'd0, bus.sat_write_done}, 32'd0);
        check("crash_valid_t1", {31'd0, bus.rpt_valid}, 32'd0);
        @(negedge clk);
        check("crash_done_t2",  {31'd0, bus.sat_write_done}, 32'd1);
        check("crash_valid_t2", {31'd0, bus.rpt_valid}, 32'd1);
        check("crash_irq",      {31'd0, bus.irq}, 32'd1);
        check("crash_status",   bus.rpt_status, 32'hDEAD0001);
        check("crash_cnt",      {16'd0, crash_cnt}, 32'd1);
        @(negedge clk);
        check("crash_done_t3",  {31'd0, bus.sat_write_done}, 32'd0);
        pop_expect("crash_pop", 32'hDEAD0001);
        check("crash_empty", {31'd0, bus.rpt_valid}, 32'd0);
        check("crash_irq0",  {31'd0, bus.irq}, 32'd0);

        // Illegal reports: wrong address, unknown class, bad sub-code, no write enable
        send(32'h8000_0004, 32'hBEEF0001, 1'b1, 1'b0, 1'b0);
        check("ill_addr_bad",   {16'd0, bad_cnt}, 32'd1);
        check("ill_addr_hang",  {16'd0, hang_cnt}, 32'd0);
        check("ill_addr_empty", {31'd0, bus.rpt_valid}, 32'd0);
        send(32'h8000_0000, 32'h12340001, 1'b1, 1'b0, 1'b0);
        send(32'h8000_0000, 32'hDEAD0003, 1'b1, 1'b0, 1'b0);
        send(32'h8000_0000, 32'hFFFF0002, 1'b0, 1'b0, 1'b0);
        check("ill_all_bad",   {16'd0, bad_cnt}, 32'd4);
        check("ill_crash",     {16'd0, crash_cnt}, 32'd1);
        check("ill_mism",      {16'd0, mism_cnt}, 32'd0);
        check("ill_empty",     {31'd0, bus.rpt_valid}, 32'd0);

        clear_counters();
        check("clr_crash", {16'd0, crash_cnt}, 32'd0);
        check("clr_bad",   {16'd0, bad_cnt}, 32'd0);

        // Queue overflow: nine reports into eight slots, no pops
        for (int i = 0; i < 9; i++) send(32'h8000_0000, 32'hC0DE0002, 1'b1, 1'b0, 1'b0);
        check("ovf_drop", {16'd0, drop_cnt}, 32'd1);
        check("ovf_cnt",  {16'd0, ovf_cnt}, 32'd9);
        check("ovf_bad",  {16'd0, bad_cnt}, 32'd0);
        for (int i = 0; i < 8; i++) pop_expect("ovf_pop", 32'hC0DE0002);
        check("ovf_valid0", {31'd0, bus.rpt_valid}, 32'd0);
        check("ovf_irq0",   {31'd0, bus.irq}, 32'd0);

        clear_counters();

        // Full queue with a pop coinciding with the push
        for (int i = 0; i < 8; i++) send(32'h8000_0000, fill[i], 1'b1, 1'b0, 1'b0);
        check("full_hold1", bus.rpt_status, fill[0]);
        @(negedge clk);
        check("full_hold2", bus.rpt_status, fill[0]);
        send(32'h8000_0000, 32'hFFFF0002, 1'b1, 1'b1, 1'b0);
        check("pp_drop",  {16'd0, drop_cnt}, 32'd0);
        check("pp_crash", {16'd0, crash_cnt}, 32'd3);
        check("pp_hang",  {16'd0, hang_cnt}, 32'd2);
        check("pp_ovf",   {16'd0, ovf_cnt}, 32'd2);
        check("pp_mism",  {16'd0, mism_cnt}, 32'd2);
        for (int i = 1; i < 8; i++) pop_expect("pp_pop", fill[i]);
        pop_expect("pp_last", 32'hFFFF0002);
        check("pp_empty", {31'd0, bus.rpt_valid}, 32'd0);

        // Saturation: preload the hang counter as if 65534 reports had arrived
        clear_counters();
        force dut.hang_cnt = 16'hFFFE;
        #1;
        release dut.hang_cnt;
        check("sat_preload", {16'd0, hang_cnt}, 32'h0000FFFE);
        send(32'h8000_0000, 32'hBEEF0001, 1'b1, 1'b0, 1'b0);
        check("sat_reach", {16'd0, hang_cnt}, 32'h0000FFFF);
        send(32'h8000_0000, 32'hBEEF0002, 1'b1, 1'b0, 1'b0);
        check("sat_hold", {16'd0, hang_cnt}, 32'h0000FFFF);
        // Queue holds two hang reports now; a coincident clear zeros everything
        send(32'h8000_0000, 32'hBEEF0001, 1'b1, 1'b0, 1'b1);
        check("clr_win_hang", {16'd0, hang_cnt}, 32'd0);
        check("clr_win_bad",  {16'd0, bad_cnt}, 32'd0);
        for (int i = 0; i < 3; i++) pop_expect("sat_pop", 32'hBEEF0001 + ((i == 1) ? 32'd1 : 32'd0));
        check("sat_empty", {31'd0, bus.rpt_valid}, 32'd0);

        // Reset while in CAPTURE with sat_req held high
        drive_req(32'h8000_0000, 32'hDEAD0001, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstc_done",  {31'd0, bus.sat_write_done}, 32'd0);
        check("rstc_crash", {16'd0, crash_cnt}, 32'd0);
        check("rstc_valid", {31'd0, bus.rpt_valid}, 32'd0);
        @(negedge clk);
        bus.sat_req = 1'b0;
        check("rstc_done_t1", {31'd0, bus.sat_write_done}, 32'd0);
        @(negedge clk);
        check("rstc_done_t2", {31'd0, bus.sat_write_done}, 32'd1);
        check("rstc_crash2",  {16'd0, crash_cnt}, 32'd1);
        check("rstc_valid2",  {31'd0, bus.rpt_valid}, 32'd1);
        check("rstc_status",  bus.rpt_status, 32'hDEAD0001);
        @(negedge clk);
        check("rstc_done_t3", {31'd0, bus.sat_write_done}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
